// File: rtl/tdm_pkg.sv
// Shared constants and state encoding for the 4-channel TDM receive demux.
package tdm_pkg;

    localparam int N_CH   = 4;
    localparam int SLOT_W = 2;

    // Frame-alignment states: HUNT waits for a frame sync, LOCKED tracks slots.
    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_t;

endpackage

// File: rtl/tdm_slot_ctr.sv
// Slot index counter: wraps modulo 2**SLOT_W, can clear to 0 or load 1.
// Clear wins over load, load wins over increment.
module tdm_slot_ctr
    import tdm_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              load1,
    input  logic              inc,
    output logic [SLOT_W-1:0] slot
);

    logic [SLOT_W-1:0] slot_reg;

    // Slot register update with clear/load/increment priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_reg <= '0;
        end else if (clr) begin
            slot_reg <= '0;
        end else if (load1) begin
            slot_reg <= SLOT_W'(1);
        end else if (inc) begin
            slot_reg <= slot_reg + SLOT_W'(1);
        end
    end

    assign slot = slot_reg;

endmodule

// File: rtl/demux1_4_tdm.sv
// Receive side of a 4-channel TDM link: routes each data beat to its
// channel holding register, tracks frame alignment, flags sync errors.
module demux1_4_tdm
    import tdm_pkg::*;
#(
    parameter int W = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [W-1:0]      din,
    input  logic              din_vld,
    input  logic              fsync,
    output logic [W-1:0]      z0,
    output logic [W-1:0]      z1,
    output logic [W-1:0]      z2,
    output logic [W-1:0]      z3,
    output logic [N_CH-1:0]   vld,
    output logic [SLOT_W-1:0] slot,
    output logic              locked,
    output logic              frame_done,
    output logic              sync_err
);

    state_t            state_reg;
    state_t            state_next;
    logic [W-1:0]      z_reg [N_CH];
    logic [N_CH-1:0]   vld_reg;
    logic [N_CH-1:0]   vld_next;
    logic              frame_done_reg;
    logic              frame_done_next;
    logic              sync_err_reg;
    logic              sync_err_next;
    logic              wr_en;
    logic [SLOT_W-1:0] wr_ch;
    logic              ctr_clr;
    logic              ctr_load1;
    logic              ctr_inc;
    logic [SLOT_W-1:0] slot_cur;

    tdm_slot_ctr u_slot_ctr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (ctr_clr),
        .load1 (ctr_load1),
        .inc   (ctr_inc),
        .slot  (slot_cur)
    );

    // Per-beat decision: which channel to write, counter action, pulses, next state.
    always_comb begin
        state_next      = state_reg;
        wr_en           = 1'b0;
        wr_ch           = '0;
        ctr_clr         = 1'b0;
        ctr_load1       = 1'b0;
        ctr_inc         = 1'b0;
        frame_done_next = 1'b0;
        sync_err_next   = 1'b0;
        if (din_vld) begin
            if (state_reg == HUNT) begin
                if (fsync) begin
                    wr_en      = 1'b1;
                    wr_ch      = '0;
                    ctr_load1  = 1'b1;
                    state_next = LOCKED;
                end
            end else begin
                if (fsync) begin
                    // A sync beat is always taken as slot 0; early if slot != 0.
                    sync_err_next = (slot_cur != '0);
                    wr_en         = 1'b1;
                    wr_ch         = '0;
                    ctr_load1     = 1'b1;
                end else if (slot_cur == '0) begin
                    // Slot 0 without sync: alignment lost, beat dropped.
                    sync_err_next = 1'b1;
                    ctr_clr       = 1'b1;
                    state_next    = HUNT;
                end else begin
                    wr_en           = 1'b1;
                    wr_ch           = slot_cur;
                    ctr_inc         = 1'b1;
                    frame_done_next = (slot_cur == SLOT_W'(N_CH - 1));
                end
            end
        end
    end

    // Channel write strobes and holding registers, one per channel.
    genvar gi;
    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_ch
            assign vld_next[gi] = wr_en && (wr_ch == SLOT_W'(gi));

            // Holding register keeps its value until its channel is written.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    z_reg[gi] <= '0;
                end else if (vld_next[gi]) begin
                    z_reg[gi] <= din;
                end
            end
        end
    endgenerate

    // FSM state and one-cycle pulse outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= HUNT;
            vld_reg        <= '0;
            frame_done_reg <= 1'b0;
            sync_err_reg   <= 1'b0;
        end else begin
            state_reg      <= state_next;
            vld_reg        <= vld_next;
            frame_done_reg <= frame_done_next;
            sync_err_reg   <= sync_err_next;
        end
    end

    assign z0         = z_reg[0];
    assign z1         = z_reg[1];
    assign z2         = z_reg[2];
    assign z3         = z_reg[3];
    assign vld        = vld_reg;
    assign slot       = slot_cur;
    assign locked     = (state_reg == LOCKED);
    assign frame_done = frame_done_reg;
    assign sync_err   = sync_err_reg;

endmodule

// File: tb/tb_demux1_4_tdm.sv
// Directed testbench for demux1_4_tdm (W=1).
// Status word layout: {vld[3:0], slot[1:0], locked, frame_done, sync_err}.
// Z word layout: {z3, z2, z1, z0}.
module tb_demux1_4_tdm;

    logic       clk;
    logic       rst_n;
    logic [0:0] din;
    logic       din_vld;
    logic       fsync;
    logic [0:0] z0, z1, z2, z3;
    logic [3:0] vld;
    logic [1:0] slot;
    logic       locked;
    logic       frame_done;
    logic       sync_err;

    int checks = 0;
    int errors = 0;

    logic [8:0] st_obs;
    logic [3:0] z_obs;

    assign st_obs = {vld, slot, locked, frame_done, sync_err};
    assign z_obs  = {z3, z2, z1, z0};

    demux1_4_tdm #(.W(1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .din        (din),
        .din_vld    (din_vld),
        .fsync      (fsync),
        .z0         (z0),
        .z1         (z1),
        .z2         (z2),
        .z3         (z3),
        .vld        (vld),
        .slot       (slot),
        .locked     (locked),
        .frame_done (frame_done),
        .sync_err   (sync_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of inputs at the falling edge, sample 1ns after the rising edge.
    task automatic cycle(input logic d, input logic v, input logic f);
        @(negedge clk);
        din     = d;
        din_vld = v;
        fsync   = f;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        din     = 1'b0;
        din_vld = 1'b0;
        fsync   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (st_obs !== 9'b0000_00_0_0_0) begin
            errors++;
            $display("FAIL reset_status: got %b expected %b", st_obs, 9'b0);
        end
        checks++;
        if (z_obs !== 4'b0000) begin
            errors++;
            $display("FAIL reset_z: got %b expected %b", z_obs, 4'b0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        $display("test_reset: status=%b z=%b", st_obs, z_obs);
    endtask

    task automatic test_hunt_discard();
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 1'b1, 1'b0);
            checks++;
            if (st_obs !== 9'b0000_00_0_0_0 || z_obs !== 4'b0000) begin
                errors++;
                $display("FAIL hunt_discard[%0d]: got status=%b z=%b expected status=%b z=%b",
                         i, st_obs, z_obs, 9'b0, 4'b0);
            end
            $display("test_hunt_discard beat %0d: status=%b z=%b", i, st_obs, z_obs);
        end
    endtask

    task automatic test_lock_frame();
        logic       d_tab  [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
        logic       f_tab  [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
        logic [8:0] st_exp [4] = '{9'b0001_01_1_0_0, 9'b0010_10_1_0_0,
                                   9'b0100_11_1_0_0, 9'b1000_00_1_1_0};
        logic [3:0] z_exp  [4] = '{4'b0001, 4'b0001, 4'b0101, 4'b1101};
        for (int i = 0; i < 4; i++) begin
            cycle(d_tab[i], 1'b1, f_tab[i]);
            checks++;
            if (st_obs !== st_exp[i] || z_obs !== z_exp[i]) begin
                errors++;
                $display("FAIL lock_frame[%0d]: got status=%b z=%b expected status=%b z=%b",
                         i, st_obs, z_obs, st_exp[i], z_exp[i]);
            end
            $display("test_lock_frame beat %0d: status=%b z=%b", i, st_obs, z_obs);
        end
        cycle(1'b0, 1'b0, 1'b0);
        checks++;
        if (st_obs !== 9'b0000_00_1_0_0 || z_obs !== 4'b1101) begin
            errors++;
            $display("FAIL lock_frame_idle: got status=%b z=%b expected status=%b z=%b",
                     st_obs, z_obs, 9'b0000_00_1_0_0, 4'b1101);
        end
    endtask

    task automatic test_gaps();
        // Preload a different frame so the gapped frame's writes are observable.
        logic       d_tab  [8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        logic       v_tab  [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        logic       f_tab  [8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        logic [8:0] st_exp [8] = '{9'b0001_01_1_0_0, 9'b0010_10_1_0_0,
                                   9'b0100_11_1_0_0, 9'b1000_00_1_1_0,
                                   9'b0001_01_1_0_0, 9'b0010_10_1_0_0,
                                   9'b0100_11_1_0_0, 9'b1000_00_1_1_0};
        logic [3:0] z_exp  [8] = '{4'b1100, 4'b1110, 4'b1010, 4'b0010,
                                   4'b0011, 4'b0001, 4'b0101, 4'b1101};
        for (int i = 0; i < 8; i++) begin
            if (i == 6) begin
                // Two idle cycles between B and C, with fsync toggled to prove it is ignored.
                for (int g = 0; g < 2; g++) begin
                    cycle(1'b1, 1'b0, 1'b1);
                    checks++;
                    if (st_obs !== 9'b0000_10_1_0_0 || z_obs !== 4'b0001) begin
                        errors++;
                        $display("FAIL gap[%0d]: got status=%b z=%b expected status=%b z=%b",
                                 g, st_obs, z_obs, 9'b0000_10_1_0_0, 4'b0001);
                    end
                    $display("test_gaps idle %0d: status=%b z=%b", g, st_obs, z_obs);
                end
            end
            cycle(d_tab[i], v_tab[i], f_tab[i]);
            checks++;
            if (st_obs !== st_exp[i] || z_obs !== z_exp[i]) begin
                errors++;
                $display("FAIL gaps[%0d]: got status=%b z=%b expected status=%b z=%b",
                         i, st_obs, z_obs, st_exp[i], z_exp[i]);
            end
            $display("test_gaps beat %0d: status=%b z=%b", i, st_obs, z_obs);
        end
    endtask

    task automatic test_early_sync();
        // Slot 0 (fsync, d=0), slot 1 (d=1), then fsync on the slot-2 beat (d=1).
        cycle(1'b0, 1'b1, 1'b1);
        cycle(1'b1, 1'b1, 1'b0);
        checks++;
        if (st_obs !== 9'b0010_10_1_0_0 || z_obs !== 4'b1110) begin
            errors++;
            $display("FAIL early_pre: got status=%b z=%b expected status=%b z=%b",
                     st_obs, z_obs, 9'b0010_10_1_0_0, 4'b1110);
        end
        cycle(1'b1, 1'b1, 1'b1);
        checks++;
        if (st_obs !== 9'b0001_01_1_0_1 || z_obs !== 4'b1111) begin
            errors++;
            $display("FAIL early_sync: got status=%b z=%b expected status=%b z=%b",
                     st_obs, z_obs, 9'b0001_01_1_0_1, 4'b1111);
        end
        $display("test_early_sync: status=%b z=%b", st_obs, z_obs);
        cycle(1'b0, 1'b0, 1'b0);
        checks++;
        if (st_obs !== 9'b0000_01_1_0_0) begin
            errors++;
            $display("FAIL early_pulse_clear: got %b expected %b", st_obs, 9'b0000_01_1_0_0);
        end
    endtask

    task automatic test_missing_sync();
        // Finish the frame: slots 1..3 with d=0, leaving z = 0001 and slot = 0.
        cycle(1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 1'b0);
        checks++;
        if (st_obs !== 9'b1000_00_1_1_0 || z_obs !== 4'b0001) begin
            errors++;
            $display("FAIL missing_pre: got status=%b z=%b expected status=%b z=%b",
                     st_obs, z_obs, 9'b1000_00_1_1_0, 4'b0001);
        end
        cycle(1'b0, 1'b1, 1'b0);
        checks++;
        if (st_obs !== 9'b0000_00_0_0_1 || z_obs !== 4'b0001) begin
            errors++;
            $display("FAIL missing_sync: got status=%b z=%b expected status=%b z=%b",
                     st_obs, z_obs, 9'b0000_00_0_0_1, 4'b0001);
        end
        $display("test_missing_sync: status=%b z=%b", st_obs, z_obs);
        cycle(1'b0, 1'b1, 1'b1);
        checks++;
        if (st_obs !== 9'b0001_01_1_0_0 || z_obs !== 4'b0000) begin
            errors++;
            $display("FAIL relock: got status=%b z=%b expected status=%b z=%b",
                     st_obs, z_obs, 9'b0001_01_1_0_0, 4'b0000);
        end
        $display("test_missing_sync relock: status=%b z=%b", st_obs, z_obs);
    endtask

    task automatic test_reset_mid();
        cycle(1'b1, 1'b1, 1'b0);
        checks++;
        if (st_obs !== 9'b0010_10_1_0_0 || z_obs !== 4'b0010) begin
            errors++;
            $display("FAIL mid_pre: got status=%b z=%b expected status=%b z=%b",
                     st_obs, z_obs, 9'b0010_10_1_0_0, 4'b0010);
        end
        // Assert reset between clock edges; outputs must clear without a clock edge.
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (st_obs !== 9'b0 || z_obs !== 4'b0) begin
            errors++;
            $display("FAIL reset_async: got status=%b z=%b expected status=%b z=%b",
                     st_obs, z_obs, 9'b0, 4'b0);
        end
        $display("test_reset_mid: status=%b z=%b", st_obs, z_obs);
        @(negedge clk);
        rst_n = 1'b1;
        // Back in HUNT: a non-sync beat is discarded.
        cycle(1'b1, 1'b1, 1'b0);
        checks++;
        if (st_obs !== 9'b0 || z_obs !== 4'b0) begin
            errors++;
            $display("FAIL post_reset_hunt: got status=%b z=%b expected status=%b z=%b",
                     st_obs, z_obs, 9'b0, 4'b0);
        end
    endtask

    initial begin
        test_reset();
        test_hunt_discard();
        test_lock_frame();
        test_gaps();
        test_early_sync();
        test_missing_sync();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
